// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one external combinational ALU between two requesters.
//            Round-robin arbitration (requester 0 preferred out of reset),
//            registered operands into the ALU, registered result + NZCV
//            capture, response returned over a valid/ready handshake.
//            Optional build macro ALU_ARB_FIXED_PRIO_EN selects strict
//            priority for requester 0 instead of round-robin.
// Ports    : clk, reset            - clock, async active-high reset
//            req{0,1}_valid/ready  - request handshake (ready is combinational)
//            req{0,1}_a/b/ctrl     - request operands and ALU control code
//            alu_a/b/ctrl          - registered operands to the ALU
//            alu_result/flags      - ALU combinational outputs {N,Z,C,V}
//            rsp_valid/ready       - response handshake
//            rsp_id/result/flags/err - registered response payload
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [CTRLW-1:0] req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [CTRLW-1:0] req1_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTRLW-1:0] alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CTRLW-1:0] c_ILLEGAL0 = CTRLW'(3'b110);
  localparam logic [CTRLW-1:0] c_ILLEGAL1 = CTRLW'(3'b111);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CTRLW-1:0] r_ctrl;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic             r_rsp_err;

  logic w_opp;
  logic w_any;
  logic w_grant;
  logic w_pick1;
  logic w_illegal;

  // An accept opportunity exists when idle, or when the pending response is
  // being consumed this cycle (enables one op every two cycles).
  assign w_opp   = (r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready);
  assign w_any   = req0_valid | req1_valid;
  assign w_grant = w_opp & w_any;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Requester 1 wins only when requester 0 is not asking.
  assign w_pick1 = req1_valid & ~req0_valid;
`else
  logic r_rr;  // 1: requester 1 preferred on the next conflict
  // On conflict the pointer decides; otherwise the sole valid requester wins.
  assign w_pick1 = (req0_valid & req1_valid) ? r_rr : req1_valid;
`endif

  assign req0_ready = w_grant & ~w_pick1;
  assign req1_ready = w_grant &  w_pick1;

  assign w_illegal = (r_ctrl == c_ILLEGAL0) || (r_ctrl == c_ILLEGAL1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_ctrl       <= '0;
      r_id         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= 4'b0000;
      r_rsp_err    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_rr         <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_EXEC: begin
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
          if (w_illegal) begin
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
            r_rsp_err    <= 1'b1;
          end else begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= alu_flags;
            r_rsp_err    <= 1'b0;
          end
        end
        S_IDLE, S_RESP: begin
          // RESP without rsp_ready leaves w_opp low: everything holds.
          if (w_grant) begin
            r_a         <= w_pick1 ? req1_a    : req0_a;
            r_b         <= w_pick1 ? req1_b    : req0_b;
            r_ctrl      <= w_pick1 ? req1_ctrl : req0_ctrl;
            r_id        <= w_pick1;
            r_rsp_valid <= 1'b0;
            r_state     <= S_EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_rr        <= ~w_pick1;
`endif
          end else if (w_opp) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_ctrl   = r_ctrl;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench for alu_share_arbiter. Provides a behavioural
//            ALU, a transaction-level reference model of the arbiter, a
//            vector table, directed corner sequences and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic [3:0]  alu_flags;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .CTRLW(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Behavioural ALU: returns {N,Z,C,V, result}. C is "no borrow" for SUB.
  // Codes 110/111 return junk so the arbiter's zeroing is visible.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] ctrl);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (ctrl)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                    v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: begin r = a - b; c = (a >= b);
                    v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return {4'hF, a + b + 32'h1234};
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  ctrl;
    logic        id;
  } op_t;
  typedef struct {
    logic        id;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        err;
  } rsp_t;

  int   m_phase;     // 0 nothing in flight, 1 executing, 2 response waiting
  logic m_pref1;     // requester 1 wins the next conflict
  op_t  m_op;
  rsp_t m_rsp;
  logic hs_id[$];
  int   hs_cyc[$];

  function automatic rsp_t model_exec(input op_t o);
    rsp_t r;
    logic [35:0] f;
    r.id = o.id;
    if (o.ctrl >= 3'd6) begin r.result = '0; r.flags = '0; r.err = 1'b1; end
    else begin f = alu_fn(o.a, o.b, o.ctrl); r.result = f[31:0]; r.flags = f[35:32]; r.err = 1'b0; end
    return r;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pref1 = 1'b0;
    m_op = '{a: '0, b: '0, ctrl: '0, id: 1'b0};
  endtask

  // One clock cycle: inputs already applied; check, advance model, tick.
  task automatic step();
    logic opp, any, g, e0, e1;
    #1;
    opp = (m_phase == 0) || (m_phase == 2 && rsp_ready);
    any = req0_valid || req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    g = !req0_valid;
`else
    g = (req0_valid && req1_valid) ? m_pref1 : req1_valid;
`endif
    e0 = opp && any && !g;
    e1 = opp && any && g;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("rsp_valid", rsp_valid, m_phase == 2);
    if (m_phase == 2) begin
      chk("rsp_id", rsp_id, m_rsp.id);
      chk("rsp_result", rsp_result, m_rsp.result);
      chk("rsp_flags", rsp_flags, m_rsp.flags);
      chk("rsp_err", rsp_err, m_rsp.err);
      if (rsp_ready) begin hs_id.push_back(m_rsp.id); hs_cyc.push_back(cycle); end
    end
    if (m_phase == 1) begin
      chk("alu_a", alu_a, m_op.a);
      chk("alu_b", alu_b, m_op.b);
      chk("alu_ctrl", alu_ctrl, m_op.ctrl);
      m_rsp = model_exec(m_op);
      m_phase = 2;
    end else if (opp) begin
      if (any) begin
        m_op = g ? '{a: req1_a, b: req1_b, ctrl: req1_ctrl, id: 1'b1}
                 : '{a: req0_a, b: req0_b, ctrl: req0_ctrl, id: 1'b0};
        m_pref1 = !g;
        m_phase = 1;
      end else m_phase = 0;
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = $urandom; req0_b = $urandom; req0_ctrl = 3'($urandom);
    req1_a = $urandom; req1_b = $urandom; req1_ctrl = 3'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  ctrl;
    logic        id;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        err;
  } vec_t;

  vec_t tbl[7];
  logic exp_ids[6];
  rsp_t held;

  initial begin
    tbl[0] = '{32'd5,        32'd3,    3'b000, 1'b0, 32'd8,        4'b0000, 1'b0};
    tbl[1] = '{32'd3,        32'd5,    3'b001, 1'b1, 32'hFFFFFFFE, 4'b1000, 1'b0};
    tbl[2] = '{32'd1,        32'd1,    3'b110, 1'b0, 32'd0,        4'b0000, 1'b1};
    tbl[3] = '{32'hF0,       32'h3C,   3'b010, 1'b0, 32'h30,       4'b0000, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 32'd1,    3'b000, 1'b1, 32'd0,        4'b0110, 1'b0};
    tbl[5] = '{32'h7FFFFFFF, 32'd1,    3'b000, 1'b0, 32'h80000000, 4'b1001, 1'b0};
    tbl[6] = '{32'd9,        32'd2,    3'b111, 1'b1, 32'd0,        4'b0000, 1'b1};

    reset = 1'b1; rsp_ready = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_flags", rsp_flags, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_alu_ctrl", alu_ctrl, 0);
    @(negedge clk);
    do_reset();

    // ---- vector table: single ops, inputs scrambled after grant ----
    foreach (tbl[i]) begin
      idle_inputs();
      rsp_ready = 1'b1;
      if (tbl[i].id) begin req1_valid = 1; req1_a = tbl[i].a; req1_b = tbl[i].b; req1_ctrl = tbl[i].ctrl; end
      else           begin req0_valid = 1; req0_a = tbl[i].a; req0_b = tbl[i].b; req0_ctrl = tbl[i].ctrl; end
      step();            // cycle N: grant
      idle_inputs();
      step();            // N+1: execute
      #1;
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_id", rsp_id, tbl[i].id);
      chk("vec_rsp_result", rsp_result, tbl[i].res);
      chk("vec_rsp_flags", rsp_flags, tbl[i].flg);
      chk("vec_rsp_err", rsp_err, tbl[i].err);
      step();            // N+2: response consumed
    end

    // ---- both valid continuously: id order and 2-cycle cadence ----
    do_reset();
    hs_id.delete(); hs_cyc.delete();
    rsp_ready = 1'b1;
    for (int k = 0; k < 30 && hs_id.size() < 6; k++) begin
      idle_inputs(); req0_valid = 1; req1_valid = 1;
      step();
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 0, 1, 0, 1};
`endif
    chk("b2b_count", hs_id.size(), 6);
    for (int k = 0; k < 6 && k < hs_id.size(); k++) chk("b2b_id", hs_id[k], exp_ids[k]);
    for (int k = 1; k < 6 && k < hs_id.size(); k++) chk("b2b_gap", hs_cyc[k] - hs_cyc[k-1], 2);

    // ---- stall: rsp_ready low 5 cycles with both requesting ----
    do_reset();
    idle_inputs(); req0_valid = 1; req1_valid = 1; rsp_ready = 1'b0;
    step(); step();
    #1;
    held = '{id: rsp_id, result: rsp_result, flags: rsp_flags, err: rsp_err};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_ready0", req0_ready, 0);
      chk("stall_ready1", req1_ready, 0);
      chk("stall_result", rsp_result, held.result);
      chk("stall_id", rsp_id, held.id);
      req0_a = $urandom; req1_a = $urandom;
      step();
    end
    rsp_ready = 1'b1;
    #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("release_grant0", req0_ready, 1);
`else
    chk("release_grant1", req1_ready, 1);
`endif
    step();
    idle_inputs();
    step(); step();

    // ---- reset during execute ----
    do_reset();
    idle_inputs(); req0_valid = 1; req0_a = 32'h55; req0_b = 32'h66; req0_ctrl = 3'b011;
    step();            // grant req0 (pointer now prefers 1)
    idle_inputs();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_exec_rsp_valid", rsp_valid, 0);
    chk("rst_exec_alu_a", alu_a, 0);
    chk("rst_exec_alu_b", alu_b, 0);
    chk("rst_exec_alu_ctrl", alu_ctrl, 0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) step();
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("post_rst_grant0", req0_ready, 1);
    step();
    idle_inputs();
    step(); step();

    // ---- random traffic against the model ----
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_a = $urandom; req0_b = $urandom; req0_ctrl = 3'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_ctrl = 3'($urandom);
      if ($urandom_range(0, 7) == 0) begin req0_a = 32'hFFFFFFFF; req1_b = 32'h0; end
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
